// File: rtl/mdu_iter_if.sv
// Handshake/data bundle between the pipeline and the mdu_iter HI/LO unit.
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       func;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] wdata;
  logic             hi_we;
  logic             lo_we;
  logic             busy;
  logic             done;
  logic             dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, func, a, b, wdata, hi_we, lo_we,
    input  busy, done, dz, hi, lo
  );

  modport slave (
    input  start, func, a, b, wdata, hi_we, lo_we,
    output busy, done, dz, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative MULTU/MULT/DIVU/DIV unit owning HI/LO, one radix-2 step per cycle.
// Optional early termination on trivial operands: define MDU_EARLY_OUT_EN.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input logic      clk,
  input logic      reset,
  mdu_iter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  state_t           state, state_nxt;
  logic             is_div, neg_q, neg_r, bz;
  logic [WIDTH-1:0] d, rem, q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             done_r, dz_r;

  logic             is_signed, early;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    is_signed = bus.func[0];
    mag_a     = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    mag_b     = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  end

`ifdef MDU_EARLY_OUT_EN
  assign early = bus.func[1] ? ((bus.b != '0) && (mag_a < mag_b))
                             : ((mag_a == '0) || (mag_b == '0));
`else
  assign early = 1'b0;
`endif

  // rem/q form one 2W shift register: {rem,q} is the running product for
  // multiplies and the partial remainder / dividend-quotient pair for divides.
  always_comb begin
    mul_sum  = {1'b0, rem} + (q[0] ? {1'b0, d} : '0);
    div_sh   = {rem, q[WIDTH-1]};
    div_diff = div_sh - {1'b0, d};
    prod     = neg_q ? -{rem, q} : {rem, q};
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.start) state_nxt = early ? FIX : RUN;
      RUN:  if (cnt == CNT_LAST) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      bz     <= 1'b0;
      d      <= '0;
      rem    <= '0;
      q      <= '0;
      cnt    <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.hi_we) hi_r <= bus.wdata;
          if (bus.lo_we) lo_r <= bus.wdata;
          if (bus.start) begin
            is_div <= bus.func[1];
            neg_q  <= is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_r  <= is_signed && bus.a[WIDTH-1];
            bz     <= bus.func[1] && (bus.b == '0);
            cnt    <= CNT_INIT;
            // Early exit preloads the final remainder/product so FIX is unchanged.
            if (early) begin
              rem <= bus.func[1] ? mag_a : '0;
              q   <= '0;
            end else if (bus.func[1]) begin
              rem <= '0;
              q   <= mag_a;
              d   <= mag_b;
            end else begin
              rem <= '0;
              q   <= mag_b;
              d   <= mag_a;
            end
          end
        end
        RUN: begin
          cnt <= cnt - CNT_LAST;
          if (is_div) begin
            if (!div_diff[WIDTH]) begin
              rem <= div_diff[WIDTH-1:0];
              q   <= {q[WIDTH-2:0], 1'b1};
            end else begin
              rem <= div_sh[WIDTH-1:0];
              q   <= {q[WIDTH-2:0], 1'b0};
            end
          end else begin
            rem <= mul_sum[WIDTH:1];
            q   <= {mul_sum[0], q[WIDTH-1:1]};
          end
        end
        FIX: begin
          done_r <= 1'b1;
          if (is_div) begin
            // With b==0 every trial subtract succeeds: q is all ones, rem is |a|.
            lo_r <= bz ? '1 : (neg_q ? -q : q);
            hi_r <= neg_r ? -rem : rem;
            dz_r <= bz;
          end else begin
            hi_r <= prod[2*WIDTH-1:WIDTH];
            lo_r <= prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_r;
  assign bus.dz   = dz_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed cases plus randomized ops vs. an arithmetic model.
module tb_mdu_iter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;

  mdu_iter_if #(.WIDTH(W)) bus ();

  mdu_iter #(.WIDTH(W), .CW(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [31:0] m_hi, m_lo;
  logic        m_dz;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference results straight from the arithmetic definition of each op.
  task automatic model(input logic [1:0] f, input logic [31:0] av, input logic [31:0] bv,
                       output logic [31:0] eh, output logic [31:0] el, output int cyc);
    longint sa, sb, qq, rr;
    logic [63:0] up;
    logic [31:0] ma, mb;
    sa = longint'(int'(av));
    sb = longint'(int'(bv));
    eh = '0;
    el = '0;
    case (f)
      2'd0: begin up = {32'h0, av} * {32'h0, bv}; eh = up[63:32]; el = up[31:0]; end
      2'd1: begin up = 64'(sa * sb); eh = up[63:32]; el = up[31:0]; end
      2'd2: begin
        if (bv == 32'h0) begin el = 32'hFFFF_FFFF; eh = av; end
        else begin el = av / bv; eh = av % bv; end
      end
      default: begin
        if (bv == 32'h0) begin el = 32'hFFFF_FFFF; eh = av; end
        else begin qq = sa / sb; rr = sa % sb; el = 32'(qq); eh = 32'(rr); end
      end
    endcase
    ma = (f[0] && av[31]) ? 32'(-sa) : av;
    mb = (f[0] && bv[31]) ? 32'(-sb) : bv;
    cyc = W + 1;
`ifdef MDU_EARLY_OUT_EN
    if (!f[1] && (ma == 32'h0 || mb == 32'h0)) cyc = 1;
    else if (f[1] && bv != 32'h0 && ma < mb) cyc = 1;
`else
    if (ma == 32'h0 && mb == 32'h1) cyc = W + 1;
`endif
  endtask

  // Runs one op; poke>0 injects a stray start plus hi_we at that busy cycle,
  // wr_lo issues lo_we together with start.
  task automatic run_op(input logic [1:0] f, input logic [31:0] av, input logic [31:0] bv,
                        input string tag, input int poke, input bit wr_lo);
    logic [31:0] eh, el;
    int exp_cyc, cyc;
    model(f, av, bv, eh, el, exp_cyc);
    @(negedge clk);
    bus.start = 1'b1; bus.func = f; bus.a = av; bus.b = bv;
    if (wr_lo) begin bus.lo_we = 1'b1; bus.wdata = 32'hA5A5_A5A5; m_lo = 32'hA5A5_A5A5; end
    @(negedge clk);
    bus.start = 1'b0; bus.lo_we = 1'b0;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 100) begin
      cyc++;
      if (cyc == 1 || cyc == 7) begin
        chk({tag, "_hold_hi"}, bus.hi, m_hi);
        chk({tag, "_hold_lo"}, bus.lo, m_lo);
        chk({tag, "_done_busy"}, bus.done, 1'b0);
      end
      if (poke > 0 && cyc == poke) begin
        bus.start = 1'b1; bus.func = 2'b11; bus.a = $urandom; bus.b = 32'd3;
        bus.hi_we = 1'b1; bus.wdata = 32'h1234;
      end
      if (poke > 0 && cyc == poke + 1) begin
        bus.start = 1'b0; bus.hi_we = 1'b0;
      end
      @(negedge clk);
    end
    if (f[1]) m_dz = (bv == 32'h0);
    m_hi = eh;
    m_lo = el;
    chk({tag, "_busy_cycles"}, cyc, exp_cyc);
    chk({tag, "_done"}, bus.done, 1'b1);
    chk({tag, "_hi"}, bus.hi, eh);
    chk({tag, "_lo"}, bus.lo, el);
    chk({tag, "_dz"}, bus.dz, m_dz);
    @(negedge clk);
    chk({tag, "_done_pulse"}, bus.done, 1'b0);
  endtask

  initial begin
    int ndone;
    logic [1:0]  rf;
    logic [31:0] ra, rb;
    reset = 1'b1;
    bus.start = 1'b0; bus.func = 2'b00; bus.a = '0; bus.b = '0;
    bus.wdata = '0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    #12;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_dz", bus.dz, 1'b0);
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 0, 1'b0);
    run_op(2'd1, 32'hFFFF_FFF9, 32'd3, "mult_neg", 0, 1'b0);
    run_op(2'd3, 32'hFFFF_FFF9, 32'd2, "div_neg", 0, 1'b0);
    run_op(2'd2, 32'd100, 32'd0, "divu_dz", 0, 1'b0);
    run_op(2'd0, 32'd12345, 32'd678, "multu_keepdz", 0, 1'b0);
    run_op(2'd2, 32'd100, 32'd7, "divu_poke", 5, 1'b0);
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_min", 0, 1'b0);
    run_op(2'd3, 32'hFFFF_FF9C, 32'd0, "div_dz_neg", 0, 1'b0);
    run_op(2'd0, 32'd0, 32'd5, "multu_zero", 0, 1'b0);
    run_op(2'd2, 32'd3, 32'd9, "divu_small", 0, 1'b0);
    run_op(2'd1, 32'd7, 32'h1234, "mult_wr_lo", 0, 1'b1);

    @(negedge clk);
    bus.hi_we = 1'b1; bus.wdata = 32'h1234;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h5678;
    m_hi = 32'h1234;
    chk("idle_hi_we", bus.hi, m_hi);
    chk("idle_lo_keep", bus.lo, m_lo);
    @(negedge clk);
    bus.lo_we = 1'b0;
    m_lo = 32'h5678;
    chk("idle_lo_we", bus.lo, m_lo);

    run_op(2'd2, 32'd5, 32'd0, "divu_dz2", 0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1; bus.func = 2'd0; bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_hi", bus.hi, 32'h0);
    chk("midrst_lo", bus.lo, 32'h0);
    chk("midrst_dz", bus.dz, 1'b0);
    chk("midrst_done", bus.done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    run_op(2'd2, 32'd100, 32'd7, "after_rst", 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rf = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 20);
      case ($urandom_range(0, 3))
        0:       rb = 32'h0;
        1:       rb = $urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      run_op(rf, ra, rb, $sformatf("rnd%0d", i), 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
